my_xor2_wdff: RTL and testbench
===============================

# my_xor2_wdff

Registered two-input XOR: O is the XOR of IN_A and IN_B, captured in a D flip-flop on the rising edge of CLK. The flip-flop has a clock enable and a synchronous active-high reset. This is a leaf cell used wherever a glitch-free, clock-aligned XOR result is needed, for example in parity, toggle-detect or compare paths.

## Interface
- WIDTH, default 1: bit width of IN_A, IN_B and O. The operation is bitwise and lanes are independent.
- RESET_VALUE, default all-zero (WIDTH bits): value loaded into O on reset.
- CLK  input  1  the single clock; all state updates on its rising edge.
- RESET  input  1  reset; synchronous and active-high.
- CE  input  1  clock enable, active-high.
- IN_A  input  WIDTH  XOR operand A.
- IN_B  input  WIDTH  XOR operand B.
- O  output  WIDTH  registered XOR result, driven directly from a flop.

## Operation
- At each rising CLK edge, in priority order:
  - RESET=1: O <= RESET_VALUE. This applies regardless of CE.
  - RESET=0, CE=1: O <= IN_A ^ IN_B (bitwise).
  - RESET=0, CE=0: O holds its value.
- There is no asynchronous path: a RESET pulse that does not span a rising edge has no effect.
- There is no combinational path from the inputs to O.
- The power-up value is undefined until the first edge with RESET=1 or CE=1.
- The block has no FSM; its only state is the output register (plus the input register when it is configured in).

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on O after edge N. With the input-register option it is 2 cycles.
- The inputs must meet setup/hold to CLK. Input changes between edges are ignored.
- Reset takes effect at the first rising edge with RESET=1, and O is valid (RESET_VALUE) after that edge.
- If RESET and CE are both asserted, reset wins.
- If CE is deasserted in mid-stream, O freezes at the last captured value. A later reset still clears it at the next edge where RESET=1.

## Configuration
- MY_XOR2_WDFF_INREG_EN defined:
  - IN_A and IN_B are first captured into WIDTH-bit input registers. These use the same CE and RESET, and reset to 0.
  - The XOR of the registered values is then captured into O.
  - Latency is 2 cycles.
- Not defined: single register stage with 1-cycle latency, as described above.

## Structure
- Shared package my_xor2_wdff_pkg holds:
  - the default WIDTH constant (1);
  - the default RESET_VALUE constant ('0);
  - the latency constants: 1 cycle, or 2 cycles with the input-register option.
- One sub-module, dff_ce_sr: a parameterised WIDTH-bit D flip-flop with CE and synchronous active-high reset to a parameter value.
  - It is instantiated once for O.
  - It is instantiated twice more (IN_A, IN_B) under MY_XOR2_WDFF_INREG_EN.
- The top level contains only the XOR and the instances.

## Test plan
All scenarios use WIDTH=1, a 2000 ps clock period and rising edges at 1000 + 2000k ps.

- **Stimulus sequence.** RESET=1 at the edge at 1000, then RESET=0 with CE=1. IN_A and IN_B start at 0. IN_A=1 at 10000, IN_B=1 at 20000, IN_A=0 at 30000, IN_A=1 at 60000.
  - O=0 from the 1000 edge.
  - O=1 after the 11000 edge.
  - O=0 after the 21000 edge.
  - O=1 after the 31000 edge.
  - O=0 after the 61000 edge.
- **Clock-enable hold.** CE=0 from 100000, then the inputs are toggled.
  - O holds its value across all subsequent edges.
- **Reset pulse between edges.** RESET is high only from 100100 to 100200.
  - O is unchanged, because the reset is synchronous.
- **Reset over enable.** RESET=1 and CE=1 at the same edge with IN_A ^ IN_B = 1.
  - O=RESET_VALUE (0) after that edge.
  - With RESET_VALUE=1, O=1 after that edge.
- **Lane independence.** WIDTH=8, IN_A=0xA5, IN_B=0x0F, CE=1.
  - O=0xAA one edge later.
- **Input-register option.** With MY_XOR2_WDFF_INREG_EN defined, IN_A rises from 0 to 1 with IN_B=0.
  - O rises to 1 two edges later, not one.

Source files
------------

// File: rtl/my_xor2_wdff_pkg.sv
// my_xor2_wdff_pkg: shared defaults and pipeline latency for the registered XOR cell.
// Optional input-register stage is selected with MY_XOR2_WDFF_INREG_EN.
`default_nettype none

package my_xor2_wdff_pkg;

  localparam int   DEFAULT_WIDTH       = 1;
  localparam logic DEFAULT_RESET_VALUE = 1'b0;

`ifdef MY_XOR2_WDFF_INREG_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 1;
`endif

endpackage

`default_nettype wire

// File: rtl/my_xor2_wdff_dff_ce_sr.sv
// dff_ce_sr: WIDTH-bit D flip-flop with clock enable and synchronous active-high reset.
// Revision 1.0
`default_nettype none

module dff_ce_sr
  import my_xor2_wdff_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset outranks the enable so a frozen register can still be cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/my_xor2_wdff.sv
// my_xor2_wdff: bitwise XOR of IN_A and IN_B captured in a CE/sync-reset flop.
// Define MY_XOR2_WDFF_INREG_EN to register the operands first (2-cycle latency).
`default_nettype none

module my_xor2_wdff
  import my_xor2_wdff_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  output logic [WIDTH-1:0] O
);

  logic [WIDTH-1:0] xor_a;
  logic [WIDTH-1:0] xor_b;
  logic [WIDTH-1:0] xor_d;

`ifdef MY_XOR2_WDFF_INREG_EN
  dff_ce_sr #(
    .WIDTH       (WIDTH),
    .RESET_VALUE ('0)
  ) u_reg_a (
    .clk (CLK),
    .rst (RESET),
    .ce  (CE),
    .d   (IN_A),
    .q   (xor_a)
  );

  dff_ce_sr #(
    .WIDTH       (WIDTH),
    .RESET_VALUE ('0)
  ) u_reg_b (
    .clk (CLK),
    .rst (RESET),
    .ce  (CE),
    .d   (IN_B),
    .q   (xor_b)
  );
`else
  assign xor_a = IN_A;
  assign xor_b = IN_B;
`endif

  assign xor_d = xor_a ^ xor_b;

  dff_ce_sr #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_reg_o (
    .clk (CLK),
    .rst (RESET),
    .ce  (CE),
    .d   (xor_d),
    .q   (O)
  );

endmodule

`default_nettype wire

// File: tb/tb_my_xor2_wdff.sv
// tb_my_xor2_wdff: directed self-checking bench for my_xor2_wdff (1-bit, 1-bit reset-high, 8-bit).
`default_nettype none
`timescale 1ps/1ps

module tb_my_xor2_wdff;

  localparam int LAT = my_xor2_wdff_pkg::LATENCY;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       a;
  logic       b;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       o1;
  logic       o_rv1;
  logic [7:0] o8;

  int total = 0;
  int bad   = 0;

  my_xor2_wdff #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut (
    .CLK(clk), .RESET(rst), .CE(ce), .IN_A(a), .IN_B(b), .O(o1)
  );

  my_xor2_wdff #(.WIDTH(1), .RESET_VALUE(1'b1)) u_dut_rv1 (
    .CLK(clk), .RESET(rst), .CE(ce), .IN_A(a), .IN_B(b), .O(o_rv1)
  );

  my_xor2_wdff #(.WIDTH(8), .RESET_VALUE(8'h3C)) u_dut8 (
    .CLK(clk), .RESET(rst), .CE(ce), .IN_A(a8), .IN_B(b8), .O(o8)
  );

  initial begin
    clk = 1'b0;
    forever #1000 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic goto(input time t);
    if (t > $time) #(t - $time);
  endtask

  // Apply new 1-bit operands, then check O on each edge until the new result is due.
  task automatic change1(input string tag, input logic na, input logic nb,
                         input logic old_exp, input logic new_exp);
    a = na;
    b = nb;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #500;
      check_val(tag, {7'b0, o1}, {7'b0, (k < LAT) ? old_exp : new_exp});
    end
  endtask

  task automatic change8(input string tag, input logic [7:0] na, input logic [7:0] nb,
                         input logic [7:0] old_exp, input logic [7:0] new_exp);
    a8 = na;
    b8 = nb;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #500;
      check_val(tag, o8, (k < LAT) ? old_exp : new_exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    a8  = 8'h00;
    b8  = 8'h00;

    // Reset edge at 1000
    @(posedge clk);
    #500;
    check_val("reset_o", {7'b0, o1}, 8'h00);
    check_val("reset_rv1", {7'b0, o_rv1}, 8'h01);
    check_val("reset_o8", o8, 8'h3C);
    goto(2000);
    rst = 1'b0;

    goto(9500);
    check_val("idle_o", {7'b0, o1}, 8'h00);
    check_val("idle_rv1", {7'b0, o_rv1}, 8'h00);
    check_val("idle_o8", o8, 8'h00);

    goto(10000);  change1("a_rise", 1'b1, 1'b0, 1'b0, 1'b1);
    goto(20000);  change1("b_rise", 1'b1, 1'b1, 1'b1, 1'b0);
    goto(30000);  change1("a_fall", 1'b0, 1'b1, 1'b0, 1'b1);
    goto(60000);  change1("a_rise2", 1'b1, 1'b1, 1'b1, 1'b0);
    goto(80000);  change1("b_fall", 1'b1, 1'b0, 1'b0, 1'b1);

    // Freeze with O=1, then toggle inputs and pulse reset between edges
    goto(100000);
    ce = 1'b0;
    a  = 1'b1;
    b  = 1'b1;
    a8 = 8'hFF;
    b8 = 8'h01;
    goto(100100);
    rst = 1'b1;
    goto(100200);
    rst = 1'b0;
    @(posedge clk);
    #500;
    check_val("hold_pulse", {7'b0, o1}, 8'h01);
    check_val("hold_o8", o8, 8'h00);
    goto(104000);
    a = 1'b0;
    b = 1'b1;
    goto(104600);
    a = 1'b0;
    b = 1'b0;
    goto(109500);
    check_val("hold_late", {7'b0, o1}, 8'h01);
    check_val("hold_late_o8", o8, 8'h00);

    // Reset while disabled still clears
    goto(110000);
    rst = 1'b1;
    @(posedge clk);
    #500;
    check_val("rst_no_ce", {7'b0, o1}, 8'h00);
    check_val("rst_no_ce_rv1", {7'b0, o_rv1}, 8'h01);
    goto(112000);
    rst = 1'b0;

    // Reset and enable together with XOR=1: reset wins
    goto(120000);
    ce  = 1'b1;
    a   = 1'b1;
    b   = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #500;
    check_val("rst_over_ce", {7'b0, o1}, 8'h00);
    check_val("rst_over_ce_rv1", {7'b0, o_rv1}, 8'h01);
    check_val("rst_over_ce_o8", o8, 8'h3C);
    goto(122000);
    rst = 1'b0;
    goto(129500);
    check_val("post_rst", {7'b0, o1}, 8'h01);
    goto(130000);
    a = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #500;
      check_val("rv1_follow", {7'b0, o_rv1}, (k < LAT) ? 8'h01 : 8'h00);
    end

    // Lane independence on the 8-bit instance (settled value is 0xFE from FF^01)
    goto(140000);
    check_val("o8_settle", o8, 8'hFE);
    change8("lanes_a5_0f", 8'hA5, 8'h0F, 8'hFE, 8'hAA);
    goto(150000);
    change8("lanes_5a_ff", 8'h5A, 8'hFF, 8'hAA, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
